// File: rtl/vector_data_packer.sv
// vector_data_packer
//   Packs the meaningful lanes of successive reduce-unit beats into full
//   N-lane vectors. Each beat carries N, M or 1 valid lanes. The chunk size
//   is latched from size_in on the first beat of every output vector. A
//   vector is emitted one cycle after the beat that fills it, or after the
//   beat that carries eof_in. A partial vector emitted on eof has its unfilled
//   lanes forced to zero.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   valid_in              input beat valid
//   eof_in                end of frame, only meaningful with valid_in
//   size_in               0=N lanes, 1=M lanes, 2=1 lane, 3 behaves as 0
//   vector_in             N lanes of DATA_WIDTH bits, lane i at [i*DW +: DW]
//   valid_out             one-cycle pulse, packed vector available
//   eof_out               last vector of the frame (qualified by valid_out)
//   num_valid_out         filled lanes in vector_out (qualified by valid_out)
//   vector_out            packed vector, lane 0 holds the oldest data
module vector_data_packer #(
    parameter int N          = 8,
    parameter int M          = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic                      eof_in,
    input  logic [1:0]                size_in,
    input  logic [N*DATA_WIDTH-1:0]   vector_in,
    output logic                      valid_out,
    output logic                      eof_out,
    output logic [$clog2(N+1)-1:0]    num_valid_out,
    output logic [N*DATA_WIDTH-1:0]   vector_out
);

    localparam int CW = $clog2(N + 1);
    localparam int VW = N * DATA_WIDTH;

    localparam logic [VW-1:0] MASK_N = '1;
    localparam logic [VW-1:0] MASK_M = {{((N - M) * DATA_WIDTH){1'b0}}, {(M * DATA_WIDTH){1'b1}}};
    localparam logic [VW-1:0] MASK_1 = {{((N - 1) * DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    localparam logic [CW-1:0] K_N = CW'(N);
    localparam logic [CW-1:0] K_M = CW'(M);
    localparam logic [CW-1:0] K_1 = CW'(1);

    typedef enum logic [1:0] {
        MODE_N = 2'd0,
        MODE_M = 2'd1,
        MODE_1 = 2'd2
    } mode_t;

    mode_t         mode;
    logic [CW-1:0] fill;
    logic [VW-1:0] pack_buf;

    mode_t         eff_mode;
    logic [CW-1:0] k;
    logic [CW-1:0] fill_next;
    logic [VW-1:0] lane_mask;
    logic [VW-1:0] merged;
    logic          emit;

    // Mode is re-evaluated only when the buffer is empty, so a size change
    // mid-vector is deferred until after the next emission.
    always_comb begin
        eff_mode = mode;
        if (fill == '0) begin
            case (size_in)
                2'd1:    eff_mode = MODE_M;
                2'd2:    eff_mode = MODE_1;
                default: eff_mode = MODE_N;
            endcase
        end
    end

    always_comb begin
        k         = K_N;
        lane_mask = MASK_N;
        case (eff_mode)
            MODE_M: begin
                k         = K_M;
                lane_mask = MASK_M;
            end
            MODE_1: begin
                k         = K_1;
                lane_mask = MASK_1;
            end
            default: begin
                k         = K_N;
                lane_mask = MASK_N;
            end
        endcase
    end

    // Lanes at and above fill are always zero in pack_buf, so OR-merging the
    // shifted chunk is enough. K divides N and fill is a multiple of K, so the
    // chunk never spills past lane N-1.
    always_comb begin
        fill_next = fill + k;
        merged    = pack_buf | ((vector_in & lane_mask) << (32'(fill) * DATA_WIDTH));
        emit      = (fill_next == K_N) || eof_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode          <= MODE_N;
            fill          <= '0;
            pack_buf      <= '0;
            valid_out     <= 1'b0;
            eof_out       <= 1'b0;
            num_valid_out <= '0;
            vector_out    <= '0;
        end else begin
            valid_out     <= 1'b0;
            eof_out       <= 1'b0;
            num_valid_out <= '0;
            if (valid_in) begin
                mode <= eff_mode;
                if (emit) begin
                    vector_out    <= merged;
                    valid_out     <= 1'b1;
                    eof_out       <= eof_in;
                    num_valid_out <= fill_next;
                    fill          <= '0;
                    pack_buf      <= '0;
                end else begin
                    fill     <= fill_next;
                    pack_buf <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_data_packer.sv
// tb_vector_data_packer
//   Directed test of vector_data_packer (N=8, M=4, DATA_WIDTH=32).
//   Inputs change on the falling edge. Outputs are sampled 1 ns after the
//   rising edge that consumes a beat.
module tb_vector_data_packer;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int DW = 32;
    localparam int VW = N * DW;

    logic           clk;
    logic           rst;
    logic           valid_in;
    logic           eof_in;
    logic [1:0]     size_in;
    logic [VW-1:0]  vector_in;
    logic           valid_out;
    logic           eof_out;
    logic [3:0]     num_valid_out;
    logic [VW-1:0]  vector_out;

    int n_chk = 0;
    int n_err = 0;

    vector_data_packer #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .eof_in        (eof_in),
        .size_in       (size_in),
        .vector_in     (vector_in),
        .valid_out     (valid_out),
        .eof_out       (eof_out),
        .num_valid_out (num_valid_out),
        .vector_out    (vector_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] lanes8(input logic [31:0] a0, a1, a2, a3,
                                             a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Present one beat, let it be clocked in, then return at the sample point.
    task automatic beat(input logic [1:0] sz, input logic eof, input logic [VW-1:0] v);
        @(negedge clk);
        valid_in  = 1'b1;
        size_in   = sz;
        eof_in    = eof;
        vector_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        eof_in   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic e,
                           input logic [3:0] n, input logic [VW-1:0] d);
        chk({tag, ".valid"}, VW'(valid_out), VW'(v));
        chk({tag, ".eof"},   VW'(eof_out),   VW'(e));
        chk({tag, ".num"},   VW'(num_valid_out), VW'(n));
        chk({tag, ".data"},  vector_out, d);
    endtask

    logic [VW-1:0] va, vb, vc, fill_dead, fill_ff;

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        eof_in    = 1'b0;
        size_in   = 2'd0;
        vector_in = '0;
        fill_dead = lanes8(0, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
        fill_ff   = lanes8(0, 0, 0, 0, 32'hFF, 32'hFF, 32'hFF, 32'hFF);

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 1'b0, 4'd0, '0);
        @(negedge clk);
        rst = 1'b0;

        // 1: full-width passthrough, back to back
        va = lanes8(0, 1, 2, 3, 4, 5, 6, 7);
        vb = lanes8(10, 11, 12, 13, 14, 15, 16, 17);
        beat(2'd0, 1'b0, va);
        chk_out("t1.a", 1'b1, 1'b0, 4'd8, va);
        beat(2'd0, 1'b0, vb);
        chk_out("t1.b", 1'b1, 1'b0, 4'd8, vb);
        idle();
        chk_out("t1.idle", 1'b0, 1'b0, 4'd0, vb);

        // 2: single-lane packing
        for (int i = 1; i <= 8; i++) begin
            beat(2'd2, 1'b0, fill_dead | VW'(i));
            if (i < 8) chk($sformatf("t2.nv%0d", i), VW'(valid_out), '0);
        end
        chk_out("t2.out", 1'b1, 1'b0, 4'd8, lanes8(1, 2, 3, 4, 5, 6, 7, 8));

        // 3: M-lane packing, upper lanes must be dropped
        beat(2'd1, 1'b0, fill_ff | lanes8(1, 2, 3, 4, 0, 0, 0, 0));
        chk("t3.nv", VW'(valid_out), '0);
        beat(2'd1, 1'b0, fill_ff | lanes8(5, 6, 7, 8, 0, 0, 0, 0));
        chk_out("t3.out", 1'b1, 1'b0, 4'd8, lanes8(1, 2, 3, 4, 5, 6, 7, 8));

        // 4: partial flush on eof, then a fresh vector
        beat(2'd2, 1'b0, fill_dead | VW'(7));
        beat(2'd2, 1'b0, fill_dead | VW'(8));
        beat(2'd2, 1'b1, fill_dead | VW'(9));
        chk_out("t4.flush", 1'b1, 1'b1, 4'd3, lanes8(7, 8, 9, 0, 0, 0, 0, 0));
        beat(2'd2, 1'b1, fill_dead | VW'(5));
        chk_out("t4.fresh", 1'b1, 1'b1, 4'd1, lanes8(5, 0, 0, 0, 0, 0, 0, 0));

        // 5: mode change deferred until after the emission
        beat(2'd2, 1'b0, fill_dead | VW'(3));
        beat(2'd2, 1'b0, fill_dead | VW'(4));
        for (int i = 5; i <= 10; i++) begin
            beat(2'd0, 1'b0, fill_dead | VW'(i));
            if (i == 9) chk("t5.nv", VW'(valid_out), '0);
        end
        chk_out("t5.out", 1'b1, 1'b0, 4'd8, lanes8(3, 4, 5, 6, 7, 8, 9, 10));
        vc = lanes8(20, 21, 22, 23, 24, 25, 26, 27);
        beat(2'd0, 1'b0, vc);
        chk_out("t5.full", 1'b1, 1'b0, 4'd8, vc);

        // 6: async reset mid-pack discards the partial buffer
        for (int i = 1; i <= 5; i++) beat(2'd2, 1'b0, VW'(i + 40));
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6.rst", 1'b0, 1'b0, 4'd0, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            beat(2'd2, 1'b0, VW'(i));
            if (i == 3) chk("t6.nostale", VW'(valid_out), '0);
        end
        chk_out("t6.out", 1'b1, 1'b0, 4'd8, lanes8(1, 2, 3, 4, 5, 6, 7, 8));
        idle();
        chk("t6.idle", VW'(valid_out), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
